// File: rtl/led_fade_pwm.sv
// Soft-fade PWM stage: ramps each LED channel linearly toward its target level and drives a PWM pin.
// Optional quadratic brightness curve when LED_FADE_GAMMA_EN is defined; eff stays combinational (no added cycle).
module led_fade_pwm #(
    parameter int unsigned NUM_CH   = 5,
    parameter int unsigned PWM_BITS = 8,
    parameter int unsigned STEP_DIV = 49000
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic [NUM_CH-1:0] i_led,
    output logic [NUM_CH-1:0] o_led,
    output logic              o_busy
);

    localparam int unsigned         PRE_W    = $clog2(STEP_DIV);
    localparam logic [PRE_W-1:0]    PRE_LAST = PRE_W'(STEP_DIV - 1);
    localparam logic [PWM_BITS-1:0] LVL_MAX  = '1;
    localparam logic [PWM_BITS-1:0] PWM_LAST = LVL_MAX - PWM_BITS'(1);

    typedef enum logic [1:0] {
        ST_OFF     = 2'd0,
        ST_RISING  = 2'd1,
        ST_ON      = 2'd2,
        ST_FALLING = 2'd3
    } state_t;

    logic [NUM_CH-1:0]                t_q;
    logic [PRE_W-1:0]                 pre_q;
    logic [PWM_BITS-1:0]              pwm_q;
    logic                             tick_c;
    logic [NUM_CH-1:0][PWM_BITS-1:0]  lvl_all;
    logic [NUM_CH-1:0][PWM_BITS-1:0]  eff_all;
    logic [NUM_CH-1:0]                led_d;
    logic                             busy_d;

    assign tick_c = (pre_q == PRE_LAST);

    // Shared target register, step prescaler, PWM counter and output registers
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            t_q    <= '0;
            pre_q  <= '0;
            pwm_q  <= '0;
            o_led  <= '0;
            o_busy <= 1'b0;
        end else begin
            t_q    <= i_led;
            pre_q  <= tick_c ? '0 : pre_q + PRE_W'(1);
            pwm_q  <= (pwm_q == PWM_LAST) ? '0 : pwm_q + PWM_BITS'(1);
            o_led  <= led_d;
            o_busy <= busy_d;
        end
    end

    for (genvar ch = 0; ch < NUM_CH; ch++) begin : g_ch
        state_t              state_q;
        state_t              state_d;
        logic [PWM_BITS-1:0] lvl_q;
        logic [PWM_BITS-1:0] lvl_d;

        always_ff @(posedge i_clk or negedge i_rst_n) begin
            if (!i_rst_n) begin
                state_q <= ST_OFF;
                lvl_q   <= '0;
            end else begin
                state_q <= state_d;
                lvl_q   <= lvl_d;
            end
        end

        // State follows i_led so it always describes the pair (t_q, lvl) seen in the next cycle;
        // a tick therefore steps with the target that was registered before that edge.
        always_comb begin
            lvl_d   = lvl_q;
            state_d = state_q;
            case (state_q)
                ST_RISING:  if (tick_c) lvl_d = lvl_q + PWM_BITS'(1);
                ST_FALLING: if (tick_c) lvl_d = lvl_q - PWM_BITS'(1);
                default:    ;
            endcase
            if (i_led[ch]) begin
                state_d = (lvl_d == LVL_MAX) ? ST_ON : ST_RISING;
            end else begin
                state_d = (lvl_d == '0) ? ST_OFF : ST_FALLING;
            end
        end

        assign lvl_all[ch] = lvl_q;

`ifdef LED_FADE_GAMMA_EN
        localparam int unsigned SQ_W = 2 * PWM_BITS;
        logic [SQ_W-1:0] sq_c;

        assign sq_c        = SQ_W'(lvl_q) * SQ_W'(lvl_q);
        assign eff_all[ch] = (lvl_q == LVL_MAX) ? LVL_MAX : PWM_BITS'(sq_c >> PWM_BITS);
`else
        assign eff_all[ch] = lvl_q;
`endif
    end

    // PWM compare and busy reduction feeding the output registers
    always_comb begin
        led_d  = '0;
        busy_d = 1'b0;
        for (int i = 0; i < int'(NUM_CH); i++) begin
            led_d[i] = (pwm_q < eff_all[i]);
            busy_d   = busy_d | (lvl_all[i] != (t_q[i] ? LVL_MAX : '0));
        end
    end

endmodule

// File: tb/tb_led_fade_pwm.sv
// Directed bench for led_fade_pwm (PWM_BITS=4, STEP_DIV=4): reset table, rise, reversal, async reset, curve.
// Expected values follow LED_FADE_GAMMA_EN the same way the design build does.
module tb_led_fade_pwm;

    logic       clk;
    logic       rst_n;
    logic [4:0] i_led;
    logic [4:0] o_led;
    logic       o_busy;

    logic       rst_s;
    logic [4:0] led_s;
    logic [4:0] o_led_s;
    logic       busy_s;

    int n_vec;
    int n_err;

    led_fade_pwm #(.NUM_CH(5), .PWM_BITS(4), .STEP_DIV(4)) dut (
        .i_clk  (clk),
        .i_rst_n(rst_n),
        .i_led  (i_led),
        .o_led  (o_led),
        .o_busy (o_busy)
    );

    led_fade_pwm #(.NUM_CH(5), .PWM_BITS(4), .STEP_DIV(64)) dut_slow (
        .i_clk  (clk),
        .i_rst_n(rst_s),
        .i_led  (led_s),
        .o_led  (o_led_s),
        .o_busy (busy_s)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       rst_n;
        logic [4:0] led;
        int         cycles;
        logic [4:0] exp_led;
        logic       exp_busy;
    } vec_t;

`ifdef LED_FADE_GAMMA_EN
    localparam logic [4:0] E16 = 5'h00;
`else
    localparam logic [4:0] E16 = 5'h1F;
`endif

    function automatic int eff_of(input int l);
`ifdef LED_FADE_GAMMA_EN
        return (l == 15) ? 15 : (l * l) / 16;
`else
        return l;
`endif
    endfunction

    // Brightness after edge n following reset release; mode 0 = steady rise, 1 = reversal at edge 28
    function automatic int lvl_at(input int mode, input int n);
        if (n <= 0) return 0;
        if (mode == 0) return (n / 4 > 15) ? 15 : n / 4;
        if (n < 32) return n / 4;
        return (14 - n / 4 > 0) ? 14 - n / 4 : 0;
    endfunction

    function automatic int t_at(input int mode, input int n);
        return (n >= 1 && (mode == 0 || n <= 27)) ? 1 : 0;
    endfunction

    function automatic int exp_led(input int mode, input int n);
        if (n < 1) return 0;
        return (((n - 1) % 15) < eff_of(lvl_at(mode, n - 1))) ? 1 : 0;
    endfunction

    function automatic int exp_busy(input int mode, input int n);
        if (n < 1) return 0;
        return (lvl_at(mode, n - 1) != (t_at(mode, n - 1) != 0 ? 15 : 0)) ? 1 : 0;
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic do_reset(input logic [4:0] led);
        rst_n = 1'b0;
        i_led = led;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    task automatic run_profile(input int mode, input int last, input string tag);
        int cnt;
        int lo;
        int hi;
        cnt = 0;
        for (int n = 1; n <= last; n++) begin
            @(posedge clk);
            #1;
            chk({tag, "_led"}, int'(o_led), exp_led(mode, n));
            chk({tag, "_busy"}, int'(o_busy), exp_busy(mode, n));
            if (mode == 0 && n >= 16 && n <= 60) begin
                cnt += int'(o_led[0]);
                if ((n - 16) % 15 == 14) begin
                    lo = eff_of(lvl_at(0, n - 15)) - 1;
                    hi = eff_of(lvl_at(0, n - 1)) + 1;
                    n_vec++;
                    if (cnt < lo || cnt > hi) begin
                        n_err++;
                        $display("FAIL %s_duty: window ending %0d got %0d high, expected %0d..%0d", tag, n, cnt, lo, hi);
                    end
                    cnt = 0;
                end
            end
            if (mode == 1 && n == 27) i_led = 5'b00000;
        end
    endtask

    initial begin
        vec_t vecs[7];
        int   c8;
        int   c15;
        int   side;

        n_vec = 0;
        n_err = 0;
        rst_n = 1'b0;
        i_led = 5'h1F;
        rst_s = 1'b0;
        led_s = 5'b00001;

        vecs[0] = '{1'b0, 5'h1F, 10, 5'h00, 1'b0};
        vecs[1] = '{1'b1, 5'h1F, 1,  5'h00, 1'b0};
        vecs[2] = '{1'b1, 5'h1F, 3,  5'h00, 1'b1};
        vecs[3] = '{1'b1, 5'h1F, 11, 5'h00, 1'b1};
        vecs[4] = '{1'b1, 5'h1F, 1,  E16,   1'b1};
        vecs[5] = '{1'b0, 5'h1F, 1,  5'h00, 1'b0};
        vecs[6] = '{1'b0, 5'h00, 2,  5'h00, 1'b0};

        for (int v = 0; v < 7; v++) begin
            rst_n = vecs[v].rst_n;
            i_led = vecs[v].led;
            for (int c = 0; c < vecs[v].cycles; c++) begin
                @(posedge clk);
                #1;
                chk($sformatf("vec%0d_led", v), int'(o_led), int'(vecs[v].exp_led));
                chk($sformatf("vec%0d_busy", v), int'(o_busy), int'(vecs[v].exp_busy));
            end
        end

        do_reset(5'b00001);
        run_profile(0, 70, "rise");

        do_reset(5'b00001);
        run_profile(1, 64, "reversal");

        // Async reset between edges while lvl is 9, then the ramp restarts from 0
        do_reset(5'b00001);
        run_profile(0, 37, "pre_arst");
        #1;
        rst_n = 1'b0;
        #2;
        chk("arst_led", int'(o_led), 0);
        chk("arst_busy", int'(o_busy), 0);
        #1;
        rst_n = 1'b1;
        run_profile(0, 24, "post_arst");

        // Slow instance holds lvl=8 for 64 cycles and then settles at 15
        c8   = 0;
        c15  = 0;
        side = 0;
        @(posedge clk);
        #1;
        rst_s = 1'b1;
        for (int n = 1; n <= 1014; n++) begin
            @(posedge clk);
            #1;
            if (n >= 531 && n <= 545) c8 += int'(o_led_s[0]);
            if (n >= 1000 && n <= 1014) c15 += int'(o_led_s[0]);
            side |= int'(o_led_s[4:1]);
        end
        chk("curve_lvl8_high", c8, eff_of(8));
        chk("curve_lvl15_high", c15, 15);
        chk("curve_other_ch", side, 0);
        chk("curve_busy_settled", int'(busy_s), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
